// File: rtl/tm1640_rx.sv
// TM1640 two-wire bus receiver: synchronises tm_clk/tm_din, detects start/stop
// conditions and assembles LSB-first bytes with a one-cycle valid strobe.
module tm1640_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tm_clk,
  input  logic       tm_din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       first_byte,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TO_W   = 16;
  localparam int unsigned BIT_W  = 3;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  logic [SYNC_STAGES-1:0] c_sync, d_sync, fill;
  logic c_s, d_s, c_p, d_p;
  logic clk_rise, start_cond, stop_cond, edge_seen, timeout_hit;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic              first_flag, first_flag_nxt;
  logic              armed, armed_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt, to_inc;
  logic [7:0]        data_out_nxt;
  logic              data_valid_nxt, first_byte_nxt, frame_start_nxt;
  logic              frame_end_nxt, frame_err_nxt, busy_nxt;

  // Synchronisers preset to the idle level; fill marks when c_s/d_s reflect real pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_p    <= 1'b1;
      d_p    <= 1'b1;
      fill   <= '0;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], tm_clk};
      d_sync <= {d_sync[SYNC_STAGES-2:0], tm_din};
      c_p    <= c_s;
      d_p    <= d_s;
      fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign c_s        = c_sync[SYNC_STAGES-1];
  assign d_s        = d_sync[SYNC_STAGES-1];
  assign clk_rise   = c_s & ~c_p;
  assign start_cond = c_s & c_p & ~d_s & d_p;
  assign stop_cond  = c_s & c_p & d_s & ~d_p;
  assign edge_seen  = (c_s ^ c_p) | (d_s ^ d_p);

  assign to_inc      = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
  assign timeout_hit = (state == S_FRAME) && !edge_seen && (to_inc == TO_LIM);

  // State and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      first_flag  <= 1'b0;
      armed       <= 1'b0;
      to_cnt      <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      first_byte  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      first_flag  <= first_flag_nxt;
      armed       <= armed_nxt;
      to_cnt      <= to_cnt_nxt;
      data_out    <= data_out_nxt;
      data_valid  <= data_valid_nxt;
      first_byte  <= first_byte_nxt;
      frame_start <= frame_start_nxt;
      frame_end   <= frame_end_nxt;
      frame_err   <= frame_err_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state and output decode; one event per cycle: start/stop > clk_rise > timeout.
  always_comb begin
    state_nxt       = state;
    bit_cnt_nxt     = bit_cnt;
    shreg_nxt       = shreg;
    first_flag_nxt  = first_flag;
    data_out_nxt    = data_out;
    first_byte_nxt  = first_byte;
    busy_nxt        = busy;
    data_valid_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    frame_end_nxt   = 1'b0;
    frame_err_nxt   = 1'b0;
    // After reset a start is honoured only once the bus has been seen idle.
    armed_nxt       = armed | (fill[SYNC_STAGES-1] & c_s & d_s);
    to_cnt_nxt      = (state == S_IDLE || edge_seen) ? '0 : to_inc;

    case (state)
      S_IDLE: begin
        if (start_cond && armed) begin
          state_nxt       = S_FRAME;
          bit_cnt_nxt     = '0;
          first_flag_nxt  = 1'b1;
          frame_start_nxt = 1'b1;
          busy_nxt        = 1'b1;
        end
      end
      S_FRAME: begin
        if (stop_cond) begin
          frame_end_nxt = 1'b1;
          frame_err_nxt = (bit_cnt != '0);
          bit_cnt_nxt   = '0;
          busy_nxt      = 1'b0;
          state_nxt     = S_IDLE;
        end else if (start_cond) begin
          frame_start_nxt = 1'b1;
          frame_err_nxt   = (bit_cnt != '0);
          bit_cnt_nxt     = '0;
          first_flag_nxt  = 1'b1;
        end else if (clk_rise) begin
          shreg_nxt   = {d_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(7)) begin
            data_out_nxt   = {d_s, shreg[7:1]};
            data_valid_nxt = 1'b1;
            first_byte_nxt = first_flag;
            first_flag_nxt = 1'b0;
          end
        end else if (timeout_hit) begin
          frame_err_nxt = 1'b1;
          bit_cnt_nxt   = '0;
          busy_nxt      = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tm1640_rx.sv
// Bench for tm1640_rx: a bus-level model schedules expected output events per
// cycle from the pin activity it drives; one process compares every cycle.
module tb_tm1640_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 4095;
  localparam int LAT  = SYNC_STAGES + 1;
  localparam int H    = 20;
  localparam int NCYC = 16384;

  logic       clk = 1'b0;
  logic       rst, tm_clk, tm_din;
  logic [7:0] data_out;
  logic       data_valid, first_byte, frame_start, frame_end, frame_err, busy;

  tm1640_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tm_clk(tm_clk), .tm_din(tm_din),
    .data_out(data_out), .data_valid(data_valid), .first_byte(first_byte),
    .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline: strobes per cycle, held-value updates per cycle (-1 = none).
  bit e_dv[NCYC], e_fs[NCYC], e_fe[NCYC], e_err[NCYC];
  int s_data[NCYC], s_first[NCYC], s_busy[NCYC];
  int cur_data = 0, cur_first = 0, cur_busy = 0;
  int n_vec = 0, n_err = 0;
  int err_cyc = -1;

  // Bus-level model state.
  bit m_clk = 1'b1, m_din = 1'b1, m_in_frame = 1'b0, m_armed = 1'b1, m_first = 1'b0;
  int m_bits = 0, m_shreg = 0, last_edge = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      if (s_data[cyc]  >= 0) cur_data  = s_data[cyc];
      if (s_first[cyc] >= 0) cur_first = s_first[cyc];
      if (s_busy[cyc]  >= 0) cur_busy  = s_busy[cyc];
      chk("data_valid",  int'(data_valid),  int'(e_dv[cyc]));
      chk("frame_start", int'(frame_start), int'(e_fs[cyc]));
      chk("frame_end",   int'(frame_end),   int'(e_fe[cyc]));
      chk("frame_err",   int'(frame_err),   int'(e_err[cyc]));
      chk("data_out",    int'(data_out),    cur_data);
      chk("first_byte",  int'(first_byte),  cur_first);
      chk("busy",        int'(busy),        cur_busy);
    end
    if (frame_err) err_cyc = cyc;
  end

  task automatic drive_clk(input bit v);
    if (v != m_clk) begin
      if (v && m_in_frame) begin
        m_shreg = (m_shreg >> 1) | (int'(m_din) << 7);
        m_bits++;
        if (m_bits == 8) begin
          e_dv[cyc+LAT]    = 1'b1;
          s_data[cyc+LAT]  = m_shreg;
          s_first[cyc+LAT] = int'(m_first);
          m_first = 1'b0;
          m_bits  = 0;
        end
      end
      last_edge = cyc;
    end
    m_clk  = v;
    tm_clk = v;
    if (m_clk && m_din) m_armed = 1'b1;
  endtask

  task automatic drive_din(input bit v);
    if (v != m_din) begin
      if (m_clk && !v) begin
        if (m_in_frame) begin
          e_fs[cyc+LAT] = 1'b1;
          if (m_bits != 0) e_err[cyc+LAT] = 1'b1;
        end else if (m_armed) begin
          e_fs[cyc+LAT]   = 1'b1;
          s_busy[cyc+LAT] = 1;
          m_in_frame = 1'b1;
        end
        if (m_in_frame) begin
          m_bits  = 0;
          m_shreg = 0;
          m_first = 1'b1;
        end
      end else if (m_clk && v && m_in_frame) begin
        e_fe[cyc+LAT] = 1'b1;
        if (m_bits != 0) e_err[cyc+LAT] = 1'b1;
        s_busy[cyc+LAT] = 0;
        m_in_frame = 1'b0;
        m_bits     = 0;
      end
      last_edge = cyc;
    end
    m_din  = v;
    tm_din = v;
    if (m_clk && m_din) m_armed = 1'b1;
  endtask

  // Waiting with the bus frozen may abort the frame on timeout.
  task automatic wait_cyc(input int n);
    int due;
    due = last_edge + LAT + int'(TIMEOUT);
    if (m_in_frame && due < cyc + n + LAT) begin
      e_err[due]  = 1'b1;
      s_busy[due] = 0;
      m_in_frame  = 1'b0;
      m_bits      = 0;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    if (!m_clk) begin
      drive_din(1'b1); wait_cyc(H);
      drive_clk(1'b1); wait_cyc(H);
    end else if (!m_din) begin
      drive_din(1'b1); wait_cyc(H);
    end
    drive_din(1'b0); wait_cyc(H);
  endtask

  task automatic send_stop();
    if (m_din) begin
      if (m_clk) begin drive_clk(1'b0); wait_cyc(H); end
      drive_din(1'b0); wait_cyc(H);
    end
    if (!m_clk) begin drive_clk(1'b1); wait_cyc(H); end
    drive_din(1'b1); wait_cyc(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      drive_clk(1'b0); wait_cyc(H);
      drive_din(b[i]); wait_cyc(H);
      drive_clk(1'b1); wait_cyc(H);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    for (int i = cyc; i < NCYC; i++) begin
      e_dv[i] = 1'b0; e_fs[i] = 1'b0; e_fe[i] = 1'b0; e_err[i] = 1'b0;
      s_data[i] = -1; s_first[i] = -1; s_busy[i] = -1;
    end
    cur_data = 0; cur_first = 0; cur_busy = 0;
    m_in_frame = 1'b0; m_bits = 0; m_armed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst data_out", int'(data_out), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst first_byte", int'(first_byte), 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      s_data[i] = -1; s_first[i] = -1; s_busy[i] = -1;
    end
    rst = 1'b1; tm_clk = 1'b1; tm_din = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("init data_out", int'(data_out), 0);
    chk("init busy", int'(busy), 0);
    rst = 1'b0;
    wait_cyc(10);

    // 1: single command byte
    send_start(); send_bits(8'h40, 8); send_stop(); wait_cyc(10);
    chk("t1 data_out", int'(data_out), 8'h40);
    chk("t1 first_byte", int'(first_byte), 1);
    chk("t1 busy", int'(busy), 0);

    // 2: multi-byte frame
    send_start(); send_bits(8'hC0, 8); send_bits(8'h3F, 8); send_bits(8'h06, 8);
    send_stop(); wait_cyc(10);
    chk("t2 data_out", int'(data_out), 8'h06);
    chk("t2 first_byte", int'(first_byte), 0);

    // 3: partial byte then stop
    send_start(); send_bits(8'hFF, 3); send_stop(); wait_cyc(10);
    chk("t3 data_out kept", int'(data_out), 8'h06);

    // 4: repeated start mid-byte
    send_start(); send_bits(8'hFF, 5); send_start(); send_bits(8'hA5, 8);
    send_stop(); wait_cyc(10);
    chk("t4 data_out", int'(data_out), 8'hA5);
    chk("t4 first_byte", int'(first_byte), 1);

    // 5: frozen bus times out
    send_start(); send_bits(8'h03, 2);
    err_cyc = -1;
    wait_cyc(int'(TIMEOUT) + 40);
    chk("t5 timeout delay", err_cyc - last_edge, 4098);
    chk("t5 busy", int'(busy), 0);
    send_start(); send_bits(8'h5A, 8); send_stop(); wait_cyc(10);
    chk("t5 data_out", int'(data_out), 8'h5A);
    chk("t5 first_byte", int'(first_byte), 1);

    // 6: reset mid-byte with din low, clk high
    send_start(); send_bits(8'h00, 3);
    reset_pulse();
    wait_cyc(30);
    chk("t6 busy after release", int'(busy), 0);
    drive_din(1'b1); wait_cyc(H);
    send_start(); send_bits(8'h8F, 8); send_stop(); wait_cyc(10);
    chk("t6 data_out", int'(data_out), 8'h8F);
    chk("t6 first_byte", int'(first_byte), 1);

    wait_cyc(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
